// File: rtl/divider_unit_pkg.sv
// Shared CPU-wide definitions for the divider: operation and state encodings,
// datapath widths and the RV64 *W result-extension helper.
package divider_unit_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // *W results are always sign-extended from bit 31, even for unsigned ops
  function automatic logic [XLEN-1:0] word_ext(input logic word, input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    if (word) begin
      r = {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/divider_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU and their RV64 *W forms.
// Optional macro DIVIDER_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass BUSY.
module divider_unit
  import divider_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);

  div_state_t  state_r, next_state_s;
  div_op_t     op_s;
  logic [6:0]  cnt_r;
  logic [63:0] rem_r, quo_r, dsr_r, spec_res_r, result_r;
  logic        word_r, is_rem_r, neg_q_r, neg_r_r, special_r, out_valid_r;

  logic        accept_s, last_s, fast_load_s;
  logic        is_signed_s, is_rem_s, a_neg_s, b_neg_s, div_zero_s, ovf_s;
  logic [63:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, ovf_min_s, spec_res_s;
  logic [64:0] rem_sh_s, trial_s;
  logic        ge_s;
  logic [63:0] rem_nx_s, quo_nx_s, q_mag_s, q_fix_s, r_fix_s, final_s;

  assign op_s      = div_op_t'(op);
  assign in_ready  = (state_r == IDLE) && !flush;
  assign out_valid = out_valid_r;
  assign result    = result_r;

  // Operand preparation: width selection, signs, magnitudes and special-case results
  always_comb begin
    is_signed_s = (op_s == DIV) || (op_s == REM);
    is_rem_s    = (op_s == REM) || (op_s == REMU);
    if (word) begin
      a_ext_s   = is_signed_s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      b_ext_s   = is_signed_s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
      ovf_min_s = 64'hFFFF_FFFF_8000_0000;
    end else begin
      a_ext_s   = a;
      b_ext_s   = b;
      ovf_min_s = 64'h8000_0000_0000_0000;
    end
    a_neg_s    = is_signed_s && a_ext_s[63];
    b_neg_s    = is_signed_s && b_ext_s[63];
    a_mag_s    = a_neg_s ? (64'd0 - a_ext_s) : a_ext_s;
    b_mag_s    = b_neg_s ? (64'd0 - b_ext_s) : b_ext_s;
    div_zero_s = (b_ext_s == 64'd0);
    ovf_s      = is_signed_s && (a_ext_s == ovf_min_s) && (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);
    if (div_zero_s) begin
      spec_res_s = is_rem_s ? word_ext(word, a) : 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      spec_res_s = is_rem_s ? 64'd0 : word_ext(word, a);
    end
  end

  // One restoring step plus the sign fix-up of the value it would complete
  always_comb begin
    rem_sh_s = {rem_r, quo_r[63]};
    trial_s  = rem_sh_s - {1'b0, dsr_r};
    ge_s     = !trial_s[64];
    rem_nx_s = ge_s ? trial_s[63:0] : rem_sh_s[63:0];
    quo_nx_s = {quo_r[62:0], ge_s};
    q_mag_s  = word_r ? {32'd0, quo_nx_s[31:0]} : quo_nx_s;
    q_fix_s  = neg_q_r ? (64'd0 - q_mag_s) : q_mag_s;
    r_fix_s  = neg_r_r ? (64'd0 - rem_nx_s) : rem_nx_s;
    if (special_r) begin
      final_s = spec_res_r;
    end else begin
      final_s = word_ext(word_r, is_rem_r ? r_fix_s : q_fix_s);
    end
  end

  // Next-state and handshake decode
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    fast_load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          next_state_s = IDLE;
        end else if (in_valid) begin
          accept_s = 1'b1;
`ifdef DIVIDER_FAST_SPECIAL_EN
          if (div_zero_s || ovf_s) begin
            fast_load_s  = 1'b1;
            next_state_s = DONE;
          end else begin
            next_state_s = BUSY;
          end
`else
          next_state_s = BUSY;
`endif
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          next_state_s = IDLE;
        end else if (cnt_r == 7'd1) begin
          last_s       = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // Iteration datapath: load on accept, one quotient bit per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 7'd0;
      rem_r      <= 64'd0;
      quo_r      <= 64'd0;
      dsr_r      <= 64'd0;
      spec_res_r <= 64'd0;
      word_r     <= 1'b0;
      is_rem_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      special_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= word ? 7'd32 : 7'd64;
      rem_r      <= 64'd0;
      quo_r      <= word ? {a_mag_s[31:0], 32'd0} : a_mag_s;
      dsr_r      <= word ? {32'd0, b_mag_s[31:0]} : b_mag_s;
      spec_res_r <= spec_res_s;
      word_r     <= word;
      is_rem_r   <= is_rem_s;
      neg_q_r    <= a_neg_s ^ b_neg_s;
      neg_r_r    <= a_neg_s;
      special_r  <= div_zero_s || ovf_s;
    end else if ((state_r == BUSY) && !flush) begin
      cnt_r <= cnt_r - 7'd1;
      rem_r <= rem_nx_s;
      quo_r <= quo_nx_s;
    end else begin
      cnt_r <= cnt_r;
      rem_r <= rem_r;
      quo_r <= quo_r;
    end
  end

  // Result register, written only when entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 64'd0;
    end else if (fast_load_s) begin
      result_r <= spec_res_s;
    end else if (last_s) begin
      result_r <= final_s;
    end else begin
      result_r <= result_r;
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed corner cases, random operations
// against an arithmetic reference model, hold, flush and asynchronous reset.
module tb_divider_unit;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, word, flush, out_valid, out_ready;
  logic [1:0]  op;
  logic [63:0] a, b, result;

  int errors = 0;
  int checks = 0;

  divider_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: language division operators plus the RISC-V special-case rules
  function automatic logic [63:0] ref_div(input logic [1:0] o, input logic w,
                                          input logic [63:0] av, input logic [63:0] bv);
    bit sgn, want_rem;
    logic [63:0] r;
    sgn      = (o == 2'd0) || (o == 2'd2);
    want_rem = o[1];
    if (w) begin
      int sa, sb;
      int unsigned ua, ub;
      logic [31:0] r32;
      ua = av[31:0];
      ub = bv[31:0];
      sa = int'(ua);
      sb = int'(ub);
      if (ub == 0) r32 = want_rem ? ua : 32'hFFFF_FFFF;
      else if (sgn && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = want_rem ? 32'd0 : ua;
      else if (sgn) r32 = want_rem ? sa % sb : sa / sb;
      else r32 = want_rem ? ua % ub : ua / ub;
      r = {{32{r32[31]}}, r32};
    end else begin
      longint sa, sb;
      longint unsigned ua, ub;
      ua = av;
      ub = bv;
      sa = longint'(ua);
      sb = longint'(ub);
      if (ub == 0) r = want_rem ? ua : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (sgn && ua == 64'h8000_0000_0000_0000 && ub == 64'hFFFF_FFFF_FFFF_FFFF)
        r = want_rem ? 64'd0 : ua;
      else if (sgn) r = want_rem ? sa % sb : sa / sb;
      else r = want_rem ? ua % ub : ua / ub;
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic w,
                                    input logic [63:0] av, input logic [63:0] bv);
    bit sgn;
    sgn = (o == 2'd0) || (o == 2'd2);
    if (w) return (bv[31:0] == 32'd0) ||
                  (sgn && av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF);
    return (bv == 64'd0) ||
           (sgn && av == 64'h8000_0000_0000_0000 && bv == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  task automatic scramble_inputs();
    op   = 2'($urandom_range(0, 3));
    word = 1'($urandom_range(0, 1));
    a    = {$urandom, $urandom};
    b    = {$urandom, $urandom};
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                        input logic [63:0] av, input logic [63:0] bv, input int hold);
    logic [63:0] exp;
    int lat, exp_lat;
    exp     = ref_div(o, w, av, bv);
    exp_lat = w ? 33 : 65;
`ifdef DIVIDER_FAST_SPECIAL_EN
    if (is_special(o, w, av, bv)) exp_lat = 1;
`else
    if (is_special(o, w, av, bv)) exp_lat = w ? 33 : 65;
`endif
    @(negedge clk);
    in_valid = 1'b1; op = o; word = w; a = av; b = bv;
    #1 check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/in_ready_done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble_inputs();
      check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/hold_result"}, result, exp);
      check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "/in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check({tag, "/no_valid"}, 64'(seen), 64'd0);
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  ro;
    logic        rw;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    op = 2'd0; word = 1'b0; a = 64'd0; b = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);

    run_op("div_m7_2",  2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    check("div_m7_2/value", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2",  2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    check("rem_m7_2/value", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divuw",     2'd1, 1'b1, 64'h1_8000_0000, 64'd1, 0);
    check("divuw/value", result, 64'hFFFF_FFFF_8000_0000);
    run_op("divu_zero", 2'd1, 1'b0, 64'd5, 64'd0, 0);
    check("divu_zero/value", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_zero", 2'd3, 1'b0, 64'd5, 64'd0, 0);
    check("remu_zero/value", result, 64'd5);
    run_op("div_ovf",   2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("div_ovf/value", result, 64'h8000_0000_0000_0000);
    run_op("rem_ovf",   2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("rem_ovf/value", result, 64'd0);
    run_op("divw_ovf",  2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("divw_ovf/value", result, 64'hFFFF_FFFF_8000_0000);
    run_op("remw_zero", 2'd2, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0000_0000, 0);
    run_op("hold",      2'd1, 1'b0, 64'd1_000_003, 64'd97, 10);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       rb = 64'd0;
        1:       rb = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       rb = 64'($urandom_range(1, 300));
        3:       rb = {{32{1'b1}}, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if (n % 8 == 7) ra = rw ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      run_op("random", ro, rw, ra, rb, 0);
    end

    // Flush during BUSY cycle 20
    @(negedge clk);
    in_valid = 1'b1; op = 2'd0; word = 1'b0; a = 64'd100; b = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    #1 check("flush_busy/in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy/valid", 64'(out_valid), 64'd0);
    watch_no_valid("flush_busy", 80);

    // Request together with flush must be ignored
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'd1; word = 1'b0; a = 64'd9; b = 64'd3;
    #1 check("flush_accept/in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    watch_no_valid("flush_accept", 80);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    in_valid = 1'b1; op = 2'd1; word = 1'b0; a = 64'd1000; b = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy/valid", 64'(out_valid), 64'd0);
    check("rst_busy/result", result, 64'd0);
    check("rst_busy/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    watch_no_valid("rst_busy", 80);

    run_op("after_reset", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
